xpm_ram_be: RTL and testbench

Parametrised single-clock true dual-port RAM with per-byte write enables. It adds a selectable read-during-write mode, an optional second output register, and per-port read-valid flags. It also detects same-address collisions and runs a hardware clear sequence after reset. It is the general-purpose storage primitive for map and scratch memories; both ports serve independent masters in the same clock domain.

---
 rtl/xpm_ram_pkg.sv | 28 ++
 rtl/xpm_ram_port.sv | 99 +++++++++
 rtl/xpm_ram_be.sv | 149 ++++++++++++++
 tb/tb_xpm_ram_be.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xpm_ram_pkg.sv
// Shared definitions for the xpm_ram_be true dual-port byte-enable RAM.
//   - read-during-write mode names used by the RDW_MODE string parameter
//   - collision counter width
//   - clear-sequencer state type
//   - calc_nb(): lane count, or 0 when the word is not a whole number of lanes
package xpm_ram_pkg;

  localparam string RDW_WRITE_FIRST = "WRITE_FIRST";
  localparam string RDW_READ_FIRST  = "READ_FIRST";
  localparam string RDW_NO_CHANGE   = "NO_CHANGE";

  localparam int unsigned COLL_CNT_W = 16;

  typedef enum logic [0:0] {
    StClr,
    StRun
  } clr_state_e;

  // A zero result marks an illegal width pair; the top raises an elaboration error on it.
  function automatic int unsigned calc_nb(input int unsigned data_width,
                                          input int unsigned byte_width);
    if (byte_width == 0 || (data_width % byte_width) != 0) begin
      return 0;
    end
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/xpm_ram_port.sv
// One RAM port's output path.
//   clk, rst_n : clock, asynchronous active-low reset
//   acc        : access accepted this cycle (request already gated by the clear sequencer)
//   we         : byte write enables of the access; all zero means a read
//   din        : write data
//   rd_word    : stored word at the port address before this cycle's writes
//   dout/valid : read data and one-cycle valid, READ_LATENCY registers deep
module xpm_ram_port
  import xpm_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter string       RDW_MODE     = "WRITE_FIRST",
  parameter int unsigned READ_LATENCY = 1,
  localparam int unsigned NB          = calc_nb(DATA_WIDTH, BYTE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  acc,
  input  logic [NB-1:0]         we,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid
);

  localparam bit IsWriteFirst = (RDW_MODE == RDW_WRITE_FIRST);
  localparam bit IsReadFirst  = (RDW_MODE == RDW_READ_FIRST);
  localparam bit IsNoChange   = (RDW_MODE == RDW_NO_CHANGE);

  if (!(IsWriteFirst || IsReadFirst || IsNoChange)) begin : g_bad_rdw
    $error("xpm_ram_port: RDW_MODE must be WRITE_FIRST, READ_FIRST or NO_CHANGE");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("xpm_ram_port: READ_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] d1_d, d1_q;
  logic                  v1_d, v1_q;

  // Word as it will be stored after this port's write: enabled lanes from din.
  always_comb begin
    merged = rd_word;
    for (int unsigned k = 0; k < NB; k++) begin
      if (we[k]) merged[k*BYTE_WIDTH +: BYTE_WIDTH] = din[k*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  always_comb begin
    d1_d = d1_q;
    v1_d = 1'b0;
    if (acc) begin
      if (we == '0) begin
        d1_d = rd_word;
        v1_d = 1'b1;
      end else if (IsWriteFirst) begin
        d1_d = merged;
        v1_d = 1'b1;
      end else if (IsReadFirst) begin
        d1_d = rd_word;
        v1_d = 1'b1;
      end
      // NO_CHANGE write: output holds, no valid.
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      d1_q <= d1_d;
      v1_q <= v1_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] d2_q;
    logic                  v2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        d2_q <= d1_q;
        v2_q <= v1_q;
      end
    end

    assign dout  = d2_q;
    assign valid = v2_q;
  end else begin : g_lat1
    assign dout  = d1_q;
    assign valid = v1_q;
  end

endmodule

// File: rtl/xpm_ram_be.sv
// True dual-port single-clock RAM with per-byte write enables.
//   clk, rst_n            : shared clock, asynchronous active-low reset
//   ena/enb, wea/web      : port requests and byte write enables (zero enables = read)
//   addra/addrb, dina/dinb: word address and write data
//   douta/doutb, valida/b : read data and one-cycle valid per accepted access
//   init_busy             : post-reset zero-fill in progress; requests are ignored
//   coll_pulse/coll_count : same-address collision pulse and saturating count
//   coll_clr              : synchronous clear of coll_count (wins over an increment)
module xpm_ram_be
  import xpm_ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter string       RDW_MODE       = "WRITE_FIRST",
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter string       RAM_STYLE      = "block",
  localparam int unsigned NB            = calc_nb(DATA_WIDTH, BYTE_WIDTH),
  localparam int unsigned DEPTH         = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic [NB-1:0]         wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  output logic [DATA_WIDTH-1:0] douta,
  output logic                  valida,
  input  logic                  enb,
  input  logic [NB-1:0]         web,
  input  logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] dinb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  validb,
  output logic                  init_busy,
  output logic                  coll_pulse,
  output logic [COLL_CNT_W-1:0] coll_count,
  input  logic                  coll_clr
);

  if (NB == 0) begin : g_bad_width
    $error("xpm_ram_be: DATA_WIDTH must be a non-zero multiple of BYTE_WIDTH");
  end
  if (RAM_STYLE != "block" && RAM_STYLE != "distributed") begin : g_bad_style
    $error("xpm_ram_be: RAM_STYLE must be block or distributed");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] clr_addr_q;
  logic                  run;
  logic                  acc_a, acc_b;
  logic                  wr_a, wr_b;
  logic                  coll;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;

  assign run   = (state_q == StRun);
  assign acc_a = run & ena;
  assign acc_b = run & enb;
  assign wr_a  = acc_a & (wea != '0);
  assign wr_b  = acc_b & (web != '0);
  assign coll  = acc_a & acc_b & (addra == addrb) & ((wea != '0) | (web != '0));

  // Pre-write contents; a reader colliding with a writer therefore sees the old word.
  assign rd_a = mem[addra];
  assign rd_b = mem[addrb];

  // B lanes are applied first so A's lanes override them when both hit the same word.
  always_ff @(posedge clk) begin
    if (state_q == StClr) begin
      mem[clr_addr_q] <= '0;
    end else begin
      if (wr_b) begin
        for (int unsigned k = 0; k < NB; k++) begin
          if (web[k]) mem[addrb][k*BYTE_WIDTH +: BYTE_WIDTH] <= dinb[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
      if (wr_a) begin
        for (int unsigned k = 0; k < NB; k++) begin
          if (wea[k]) mem[addra][k*BYTE_WIDTH +: BYTE_WIDTH] <= dina[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Zero-fill sequencer: one word per cycle, busy drops after the last address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR_ON_RESET ? StClr : StRun;
      clr_addr_q <= '0;
      init_busy  <= CLEAR_ON_RESET;
    end else if (state_q == StClr) begin
      clr_addr_q <= clr_addr_q + ADDR_WIDTH'(1);
      if (clr_addr_q == '1) begin
        state_q   <= StRun;
        init_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_pulse <= 1'b0;
      coll_count <= '0;
    end else begin
      coll_pulse <= coll;
      if (coll_clr) begin
        coll_count <= '0;
      end else if (coll && coll_count != '1) begin
        coll_count <= coll_count + COLL_CNT_W'(1);
      end
    end
  end

  xpm_ram_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BYTE_WIDTH  (BYTE_WIDTH),
    .RDW_MODE    (RDW_MODE),
    .READ_LATENCY(READ_LATENCY)
  ) u_port_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .acc    (acc_a),
    .we     (wea),
    .din    (dina),
    .rd_word(rd_a),
    .dout   (douta),
    .valid  (valida)
  );

  xpm_ram_port #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BYTE_WIDTH  (BYTE_WIDTH),
    .RDW_MODE    (RDW_MODE),
    .READ_LATENCY(READ_LATENCY)
  ) u_port_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .acc    (acc_b),
    .we     (web),
    .din    (dinb),
    .rd_word(rd_b),
    .dout   (doutb),
    .valid  (validb)
  );

endmodule

// File: tb/tb_xpm_ram_be.sv
module tb_xpm_ram_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: defaults (1024 x 64, WRITE_FIRST, latency 1, clear on reset).
  logic        rst_n = 1'b0;
  logic        ena = 1'b0, enb = 1'b0, coll_clr = 1'b0;
  logic [7:0]  wea = '0, web = '0;
  logic [9:0]  addra = '0, addrb = '0;
  logic [63:0] dina = '0, dinb = '0;
  logic [63:0] douta, doutb;
  logic        valida, validb, init_busy, coll_pulse;
  logic [15:0] coll_count;

  xpm_ram_be #(
    .ADDR_WIDTH(10), .DATA_WIDTH(64), .BYTE_WIDTH(8), .RDW_MODE("WRITE_FIRST"),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1), .RAM_STYLE("block")
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta), .valida(valida),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb), .validb(validb),
    .init_busy(init_busy), .coll_pulse(coll_pulse), .coll_count(coll_count),
    .coll_clr(coll_clr)
  );

  // Small instances for the other read-during-write modes, driven on port A only.
  logic        s_rst_n = 1'b0, s_ena = 1'b0;
  logic [1:0]  s_wea = '0;
  logic [3:0]  s_addr = '0;
  logic [15:0] s_din = '0;
  logic        z_en = 1'b0;
  logic [1:0]  z_we = '0;
  logic [3:0]  z_addr = '0;
  logic [15:0] z_din = '0;
  logic [15:0] rf_douta, rf_doutb, nc_douta, nc_doutb, rf_cnt, nc_cnt;
  logic        rf_valida, rf_validb, rf_busy, rf_pulse;
  logic        nc_valida, nc_validb, nc_busy, nc_pulse;

  xpm_ram_be #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .RDW_MODE("READ_FIRST"),
    .READ_LATENCY(2), .CLEAR_ON_RESET(1'b0), .RAM_STYLE("distributed")
  ) u_rf (
    .clk(clk), .rst_n(s_rst_n),
    .ena(s_ena), .wea(s_wea), .addra(s_addr), .dina(s_din), .douta(rf_douta),
    .valida(rf_valida),
    .enb(z_en), .web(z_we), .addrb(z_addr), .dinb(z_din), .doutb(rf_doutb),
    .validb(rf_validb),
    .init_busy(rf_busy), .coll_pulse(rf_pulse), .coll_count(rf_cnt), .coll_clr(z_en)
  );

  xpm_ram_be #(
    .ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .RDW_MODE("NO_CHANGE"),
    .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1), .RAM_STYLE("block")
  ) u_nc (
    .clk(clk), .rst_n(s_rst_n),
    .ena(s_ena), .wea(s_wea), .addra(s_addr), .dina(s_din), .douta(nc_douta),
    .valida(nc_valida),
    .enb(z_en), .web(z_we), .addrb(z_addr), .dinb(z_din), .doutb(nc_doutb),
    .validb(nc_validb),
    .init_busy(nc_busy), .coll_pulse(nc_pulse), .coll_count(nc_cnt), .coll_clr(z_en)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model of the main instance: word array plus expected output registers.
  logic [63:0] mem_m [1024];
  logic [63:0] exp_da, exp_db;
  logic        exp_va, exp_vb, exp_pulse;
  logic [15:0] exp_cnt;

  function automatic logic [63:0] lane_mix(input logic [63:0] old_w, input logic [63:0] new_w,
                                           input logic [7:0] en);
    logic [63:0] r = old_w;
    for (int k = 0; k < 8; k++) if (en[k]) r[k*8 +: 8] = new_w[k*8 +: 8];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) mem_m[i] = '0;
    exp_da = '0; exp_db = '0; exp_va = 1'b0; exp_vb = 1'b0; exp_pulse = 1'b0; exp_cnt = '0;
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0; coll_clr = 1'b0;
  endtask

  // One RUN-mode clock of the main instance, predicted then compared.
  task automatic step();
    logic [63:0] old_a, old_b;
    logic        hit;
    old_a = mem_m[addra];
    old_b = mem_m[addrb];
    exp_va = ena;
    if (ena) exp_da = (wea != 0) ? lane_mix(old_a, dina, wea) : old_a;
    exp_vb = enb;
    if (enb) exp_db = (web != 0) ? lane_mix(old_b, dinb, web) : old_b;
    hit = ena && enb && (addra == addrb) && (wea != 0 || web != 0);
    // Port A wins on a lane both ports write.
    if (enb) mem_m[addrb] = lane_mix(mem_m[addrb], dinb, web);
    if (ena) mem_m[addra] = lane_mix(mem_m[addra], dina, wea);
    exp_pulse = hit;
    if (coll_clr) exp_cnt = '0;
    else if (hit && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    @(posedge clk); #1;
    check("douta", douta, exp_da);
    check("valida", {63'd0, valida}, {63'd0, exp_va});
    check("doutb", doutb, exp_db);
    check("validb", {63'd0, validb}, {63'd0, exp_vb});
    check("coll_pulse", {63'd0, coll_pulse}, {63'd0, exp_pulse});
    check("coll_count", {48'd0, coll_count}, {48'd0, exp_cnt});
    check("init_busy_run", {63'd0, init_busy}, 64'd0);
  endtask

  // Reset and zero-fill; a nonzero abort_at re-asserts reset after that many clear cycles.
  task automatic main_reset(input int abort_at);
    int  n;
    bit  saw_valid;
    idle();
    rst_n = 1'b0; #2;
    check("rst_douta", douta, 64'd0);
    check("rst_valid", {62'd0, valida, validb}, 64'd0);
    check("rst_coll", {47'd0, coll_pulse, coll_count}, 64'd0);
    check("rst_busy", {63'd0, init_busy}, 64'd1);
    rst_n = 1'b1;
    if (abort_at > 0) begin
      repeat (abort_at) begin @(posedge clk); #1; end
      check("busy_mid", {63'd0, init_busy}, 64'd1);
      rst_n = 1'b0; #2;
      rst_n = 1'b1;
    end
    // Requests during the clear must be ignored.
    ena = 1'b1; wea = 8'hFF; addra = 10'h3FF; dina = 64'hFFFF_0000_FFFF_0000;
    enb = 1'b1; web = 8'h00; addrb = 10'h3FF;
    n = 0; saw_valid = 1'b0;
    while (init_busy && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (valida || validb) saw_valid = 1'b1;
    end
    idle();
    check("busy_cycles", 64'(n), 64'd1024);
    check("valid_in_clear", {63'd0, saw_valid}, 64'd0);
    model_reset();
  endtask

  task automatic s_step();
    @(posedge clk); #1;
  endtask

  initial begin
    @(posedge clk); #1;
    main_reset(0);

    // Cleared top word reads zero with a valid one cycle later.
    ena = 1'b1; addra = 10'h3FF; step(); idle();
    check("clr_rd_3ff", douta, 64'd0);
    check("clr_rd_valid", {63'd0, valida}, 64'd1);

    // Partial byte write on A, read back on B.
    ena = 1'b1; wea = 8'h0F; addra = 10'h010; dina = 64'h1122334455667788; step(); idle();
    enb = 1'b1; addrb = 10'h010; step(); idle();
    check("be_rd_b", doutb, 64'h0000000055667788);
    check("be_validb", {63'd0, validb}, 64'd1);
    step();
    check("be_validb_pulse", {63'd0, validb}, 64'd0);

    // Both ports write the same word.
    ena = 1'b1; wea = 8'h0F; addra = 10'h020; dina = {8{8'hAA}};
    enb = 1'b1; web = 8'hFF; addrb = 10'h020; dinb = {8{8'hBB}};
    step(); idle();
    check("ww_pulse", {63'd0, coll_pulse}, 64'd1);
    check("ww_count", {48'd0, coll_count}, 64'd1);
    ena = 1'b1; addra = 10'h020; step(); idle();
    check("ww_pulse_end", {63'd0, coll_pulse}, 64'd0);
    check("ww_word", douta, 64'hBBBBBBBBAAAAAAAA);

    // Read on A while B writes the same address.
    ena = 1'b1; wea = 8'hFF; addra = 10'h030; dina = 64'h5; step(); idle();
    ena = 1'b1; addra = 10'h030; enb = 1'b1; web = 8'hFF; addrb = 10'h030; dinb = 64'h9;
    step(); idle();
    check("rw_old", douta, 64'h5);
    check("rw_count", {48'd0, coll_count}, 64'd2);
    ena = 1'b1; addra = 10'h030; step(); idle();
    check("rw_new", douta, 64'h9);

    // Write-first output on a full write.
    ena = 1'b1; wea = 8'hFF; addra = 10'h040; dina = 64'hDEAD; step(); idle();
    check("wf_dout", douta, 64'hDEAD);
    check("wf_valid", {63'd0, valida}, 64'd1);

    // Randomized traffic over a small address window to provoke collisions.
    for (int i = 0; i < 2000; i++) begin
      ena = ($urandom_range(0, 3) != 0);
      enb = ($urandom_range(0, 3) != 0);
      wea = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
      web = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
      addra = 10'h200 | 10'($urandom_range(0, 7));
      addrb = 10'h200 | 10'($urandom_range(0, 7));
      dina = {$urandom, $urandom};
      dinb = {$urandom, $urandom};
      coll_clr = ($urandom_range(0, 31) == 0);
      step();
    end
    idle();

    // Saturate the collision counter, then clear it while a collision is present.
    ena = 1'b1; enb = 1'b1; addra = 10'h100; addrb = 10'h100; wea = 8'h01; web = 8'h00;
    for (int i = 0; i < 65540; i++) begin
      dina = 64'(i);
      step();
    end
    check("cnt_sat", {48'd0, coll_count}, 64'hFFFF);
    coll_clr = 1'b1; step(); idle();
    check("cnt_clr", {48'd0, coll_count}, 64'd0);

    // Reset mid-clear must restart the full zero-fill.
    ena = 1'b1; wea = 8'hFF; addra = 10'h3FF; dina = 64'hCAFE; step();
    addra = 10'h005; step(); idle();
    main_reset(500);
    ena = 1'b1; addra = 10'h3FF; step();
    check("reclr_3ff", douta, 64'd0);
    addra = 10'h005; step(); idle();
    check("reclr_005", douta, 64'd0);

    // READ_FIRST (latency 2) and NO_CHANGE instances.
    check("rf_rst_busy", {63'd0, rf_busy}, 64'd0);
    check("nc_rst_busy", {63'd0, nc_busy}, 64'd1);
    s_rst_n = 1'b1;
    repeat (20) s_step();
    check("nc_busy_done", {63'd0, nc_busy}, 64'd0);
    s_ena = 1'b1; s_wea = 2'b11; s_addr = 4'd3; s_din = 16'h1234; s_step();
    check("nc_wr_valid", {63'd0, nc_valida}, 64'd0);
    s_din = 16'hDEAD; s_step();
    check("nc_hold", {47'd0, nc_valida, nc_douta}, 64'd0);
    s_ena = 1'b0; s_step();
    check("rf_old", {47'd0, rf_valida, rf_douta}, {47'd0, 1'b1, 16'h1234});
    s_ena = 1'b1; s_wea = 2'b00; s_step();
    check("nc_rd", {47'd0, nc_valida, nc_douta}, {47'd0, 1'b1, 16'hDEAD});
    check("rf_gap", {63'd0, rf_valida}, 64'd0);
    s_wea = 2'b01; s_din = 16'hBEEF; s_step();
    check("nc_hold2", {47'd0, nc_valida, nc_douta}, {47'd0, 1'b0, 16'hDEAD});
    check("rf_rd", {47'd0, rf_valida, rf_douta}, {47'd0, 1'b1, 16'hDEAD});
    s_wea = 2'b00; s_step();
    check("nc_rd2", {47'd0, nc_valida, nc_douta}, {47'd0, 1'b1, 16'hDEEF});
    check("rf_old2", {47'd0, rf_valida, rf_douta}, {47'd0, 1'b1, 16'hDEAD});
    s_ena = 1'b0; s_step();
    check("rf_rd2", {47'd0, rf_valida, rf_douta}, {47'd0, 1'b1, 16'hDEEF});
    s_ena = 1'b1; s_step();
    s_ena = 1'b0; s_rst_n = 1'b0; #2;
    check("rf_flush", {47'd0, rf_valida, rf_douta}, 64'd0);
    s_rst_n = 1'b1; s_step();
    check("rf_flush_valid", {63'd0, rf_valida}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
